// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry elastic pipeline stage with a valid/ready handshake
// and a synchronous flush. It decouples upstream stall timing from the
// downstream operand muxes. ready_o is decoded from registered state only, so
// there is no combinational path from ready_i to ready_o.
// Optional build macro: PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_skid_reg #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            flush_i,
    output logic [size-1:0] data_o,
    output logic            valid_o,
    input  logic            ready_i
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0]     stall_cnt_o,
    output logic [15:0]     flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [size-1:0] main_reg, main_next;
    logic [size-1:0] skid_reg, skid_next;
    logic            in_xfer;
    logic            out_xfer;

    // Handshake outputs come straight from the registered state
    assign ready_o  = (state_reg != ST_FULL);
    assign valid_o  = (state_reg != ST_EMPTY);
    assign data_o   = main_reg;
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    // State and data registers; async reset clears all buffered words
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

    // Next-state and data steering; flush empties the stage but keeps data contents
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush_i) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_next = ST_ONE;
                        main_next  = data_i;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_next = data_i;
                    end else if (in_xfer) begin
                        state_next = ST_FULL;
                        skid_next  = data_i;
                    end else if (out_xfer) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // No word can enter here because ready_o is low
                    if (out_xfer) begin
                        state_next = ST_ONE;
                        main_next  = skid_reg;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] flush_cnt_reg;

    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;

    // Saturating counters; only reset clears them, a flush does not
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (valid_o && !ready_i && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            if (flush_i && (flush_cnt_reg != 16'hFFFF)) begin
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
            end
        end
    end
`else
    // Counters are not built; the datapath above is unaffected
`endif

endmodule
